// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate L1 data cache.
// Hits are answered combinationally. A miss stalls the pipeline while the FSM
// writes back a dirty victim (if any) and then refills the line over a
// 256-bit request/acknowledge memory port.
module dcache_controller #(
  parameter int INDEX_BITS = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         cpu_req_i,
  input  logic         cpu_we_i,
  input  logic [31:0]  cpu_addr_i,
  input  logic [31:0]  cpu_data_i,
  output logic [31:0]  cpu_data_o,
  output logic         cpu_stall_o,
  output logic         mem_enable_o,
  output logic         mem_write_o,
  output logic [31:0]  mem_addr_o,
  output logic [255:0] mem_data_o,
  input  logic [255:0] mem_data_i,
  input  logic         mem_ack_i
);

  localparam int TAG_W = 27 - INDEX_BITS;
  localparam int LINES = 1 << INDEX_BITS;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITEBACK,
    ST_ALLOCATE
  } state_t;

  state_t state_q, state_d;

  // Line storage: only valid/dirty carry reset, tags and data do not.
  logic [LINES-1:0] valid_q;
  logic [LINES-1:0] dirty_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [255:0]     data_q [LINES];

  // Address of the outstanding miss, held for all memory-side addressing.
  logic [INDEX_BITS-1:0] miss_idx_q;
  logic [TAG_W-1:0]      miss_tag_q;

  // CPU address fields; the byte offset within a word is irrelevant here.
  logic [2:0]            cpu_word;
  logic [INDEX_BITS-1:0] cpu_idx;
  logic [TAG_W-1:0]      cpu_tag;
  logic [1:0]            unused_byte_off;

  assign cpu_word        = cpu_addr_i[4:2];
  assign cpu_idx         = cpu_addr_i[4+INDEX_BITS:5];
  assign cpu_tag         = cpu_addr_i[31:5+INDEX_BITS];
  assign unused_byte_off = cpu_addr_i[1:0];

  logic hit;
  logic is_idle;
  logic miss;
  logic wr_hit;
  logic refill;

  assign hit     = cpu_req_i & valid_q[cpu_idx] & (tag_q[cpu_idx] == cpu_tag);
  assign is_idle = (state_q == ST_IDLE);
  assign miss    = is_idle & cpu_req_i & ~hit;
  assign wr_hit  = is_idle & hit & cpu_we_i;
  assign refill  = (state_q == ST_ALLOCATE) & mem_ack_i;

  assign cpu_data_o  = data_q[cpu_idx][{cpu_word, 5'b0} +: 32];
  assign cpu_stall_o = ~is_idle | (cpu_req_i & ~hit);

  // FSM state register; reset returns to IDLE without a clock.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Valid/dirty bookkeeping: refill installs a clean line, a store hit dirties it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (refill) begin
        valid_q[miss_idx_q] <= 1'b1;
        dirty_q[miss_idx_q] <= 1'b0;
      end
      if (wr_hit) begin
        dirty_q[cpu_idx] <= 1'b1;
      end
    end
  end

  // Tag/data arrays and miss-address latch; an edge coinciding with reset writes nothing.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (miss) begin
        miss_idx_q <= cpu_idx;
        miss_tag_q <= cpu_tag;
      end
      if (refill) begin
        data_q[miss_idx_q] <= mem_data_i;
        tag_q[miss_idx_q]  <= miss_tag_q;
      end
      if (wr_hit) begin
        data_q[cpu_idx][{cpu_word, 5'b0} +: 32] <= cpu_data_i;
      end
    end
  end

  // Next-state and memory-port outputs; the port is idle (all zero) outside transactions.
  always_comb begin
    state_d      = state_q;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    case (state_q)
      ST_IDLE: begin
        if (cpu_req_i && !hit) begin
          if (valid_q[cpu_idx] && dirty_q[cpu_idx]) begin
            state_d = ST_WRITEBACK;
          end else begin
            state_d = ST_ALLOCATE;
          end
        end
      end
      ST_WRITEBACK: begin
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {tag_q[miss_idx_q], miss_idx_q, 5'b0};
        mem_data_o   = data_q[miss_idx_q];
        if (mem_ack_i) begin
          state_d = ST_ALLOCATE;
        end
      end
      ST_ALLOCATE: begin
        mem_enable_o = 1'b1;
        mem_addr_o   = {miss_tag_q, miss_idx_q, 5'b0};
        if (mem_ack_i) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller with a line-granular memory model
// that acknowledges on the k-th cycle of mem_enable_o.
module tb_dcache_controller;

  logic         clk = 1'b0;
  logic         rst_i;
  logic         cpu_req_i;
  logic         cpu_we_i;
  logic [31:0]  cpu_addr_i;
  logic [31:0]  cpu_data_i;
  logic [31:0]  cpu_data_o;
  logic         cpu_stall_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;

  always #5 clk = ~clk;

  dcache_controller #(.INDEX_BITS(4)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .cpu_req_i   (cpu_req_i),
    .cpu_we_i    (cpu_we_i),
    .cpu_addr_i  (cpu_addr_i),
    .cpu_data_i  (cpu_data_i),
    .cpu_data_o  (cpu_data_o),
    .cpu_stall_o (cpu_stall_o),
    .mem_enable_o(mem_enable_o),
    .mem_write_o (mem_write_o),
    .mem_addr_o  (mem_addr_o),
    .mem_data_o  (mem_data_o),
    .mem_data_i  (mem_data_i),
    .mem_ack_i   (mem_ack_i)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Memory model state
  logic [255:0] mem_lines [logic [31:0]];
  int           mem_k    = 10;
  int           cnt      = 0;
  bit           ack_late = 1'b0;
  logic [31:0]  last_wb_addr = '0;
  logic [255:0] last_wb_data = '0;
  logic [31:0]  last_rd_addr = '0;
  int           wb_cnt = 0;
  int           rd_cnt = 0;

  function automatic logic [255:0] line_of(input logic [31:0] a);
    if (mem_lines.exists(a)) return mem_lines[a];
    return '0;
  endfunction

  // Memory responder: counts enabled cycles at the falling edge and pulses ack on the k-th.
  // With ack_late set it keeps counting after the request vanishes, emulating a stale ack.
  always @(negedge clk) begin
    mem_ack_i = 1'b0;
    if (mem_enable_o || (ack_late && cnt != 0)) begin
      cnt++;
      if (cnt == mem_k) begin
        mem_ack_i = 1'b1;
        cnt = 0;
        if (mem_enable_o && mem_write_o) begin
          mem_lines[mem_addr_o] = mem_data_o;
          last_wb_addr = mem_addr_o;
          last_wb_data = mem_data_o;
          wb_cnt++;
        end else begin
          mem_data_i = line_of(mem_addr_o);
          if (mem_enable_o) begin
            last_rd_addr = mem_addr_o;
            rd_cnt++;
          end
        end
      end
    end else begin
      cnt = 0;
    end
  end

  // One CPU access: hold the request until the stall clears, count stall cycles,
  // capture load data in the first unstalled cycle, then retire on the next edge.
  task automatic access(input logic we, input logic [31:0] a, input logic [31:0] d,
                        output int stalls, output logic [31:0] rdata);
    cpu_req_i  = 1'b1;
    cpu_we_i   = we;
    cpu_addr_i = a;
    cpu_data_i = d;
    stalls     = 0;
    #1;
    while (cpu_stall_o && stalls < 200) begin
      stalls++;
      @(posedge clk);
      #1;
    end
    rdata = cpu_data_o;
    @(posedge clk);
    #1;
    cpu_req_i = 1'b0;
    cpu_we_i  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int           st;
    logic [31:0]  rd;
    logic [255:0] tmp;
    int           wb0;
    int           rd0;

    tmp = '0; tmp[32 +: 32] = 32'hDEADBEEF; tmp[64 +: 32] = 32'hCAFEF00D;
    mem_lines[32'h100] = tmp;
    tmp = '0; tmp[32 +: 32] = 32'h30000001;
    mem_lines[32'h300] = tmp;
    mem_lines[32'h500] = {8{32'h55555555}};
    tmp = '0; tmp[32 +: 32] = 32'h99990001;
    mem_lines[32'h900] = tmp;

    rst_i      = 1'b1;
    cpu_req_i  = 1'b0;
    cpu_we_i   = 1'b0;
    cpu_addr_i = '0;
    cpu_data_i = '0;
    mem_data_i = '0;
    mem_ack_i  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall",  {255'b0, cpu_stall_o},  256'd0);
    chk("rst_enable", {255'b0, mem_enable_o}, 256'd0);
    chk("rst_write",  {255'b0, mem_write_o},  256'd0);
    chk("rst_addr",   {224'b0, mem_addr_o},   256'd0);
    chk("rst_data",   mem_data_o,             256'd0);
    rst_i = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_stall", {255'b0, cpu_stall_o}, 256'd0);

    // Cold load miss: probe the miss-detect cycle first
    cpu_req_i = 1'b1; cpu_addr_i = 32'h104;
    #1;
    chk("miss_detect_stall", {255'b0, cpu_stall_o}, 256'd1);
    chk("miss_detect_en",    {255'b0, mem_enable_o}, 256'd0);
    @(posedge clk);
    #1;
    chk("alloc_en",   {255'b0, mem_enable_o}, 256'd1);
    chk("alloc_we",   {255'b0, mem_write_o},  256'd0);
    chk("alloc_addr", {224'b0, mem_addr_o},   256'h100);
    access(1'b0, 32'h104, 32'h0, st, rd);
    chk("cold_stall", st + 1, 256'd11);
    chk("cold_data",  {224'b0, rd}, 256'hDEADBEEF);

    access(1'b0, 32'h108, 32'h0, st, rd);
    chk("hit_stall", st, 256'd0);
    chk("hit_data",  {224'b0, rd}, 256'hCAFEF00D);

    access(1'b1, 32'h104, 32'h12345678, st, rd);
    chk("store_hit_stall", st, 256'd0);

    wb0 = wb_cnt; rd0 = rd_cnt;
    access(1'b0, 32'h304, 32'h0, st, rd);
    chk("dirty_stall",   st, 256'd21);
    chk("dirty_wb_cnt",  wb_cnt - wb0, 256'd1);
    chk("dirty_wb_addr", {224'b0, last_wb_addr}, 256'h100);
    chk("dirty_wb_w1",   {224'b0, last_wb_data[32 +: 32]}, 256'h12345678);
    chk("dirty_wb_w2",   {224'b0, last_wb_data[64 +: 32]}, 256'hCAFEF00D);
    chk("dirty_rd_addr", {224'b0, last_rd_addr}, 256'h300);
    chk("dirty_rd_cnt",  rd_cnt - rd0, 256'd1);
    chk("dirty_data",    {224'b0, rd}, 256'h30000001);

    wb0 = wb_cnt;
    access(1'b1, 32'h500, 32'h0BADF00D, st, rd);
    chk("store_miss_stall",  st, 256'd11);
    chk("store_miss_wb_cnt", wb_cnt - wb0, 256'd0);
    chk("store_miss_rd",     {224'b0, last_rd_addr}, 256'h500);

    access(1'b0, 32'h500, 32'h0, st, rd);
    chk("store_back_stall", st, 256'd0);
    chk("store_back_data",  {224'b0, rd}, 256'h0BADF00D);

    access(1'b0, 32'h700, 32'h0, st, rd);
    chk("evict_stall",   st, 256'd21);
    chk("evict_wb_addr", {224'b0, last_wb_addr}, 256'h500);
    chk("evict_wb_w0",   {224'b0, last_wb_data[0 +: 32]},  256'h0BADF00D);
    chk("evict_wb_w1",   {224'b0, last_wb_data[32 +: 32]}, 256'h55555555);
    chk("evict_data",    {224'b0, rd}, 256'h0);

    // Reset in the 4th ALLOCATE cycle, stale ack arrives later
    ack_late  = 1'b1;
    rd0       = rd_cnt;
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h904;
    repeat (4) @(posedge clk);
    #1;
    chk("pre_rst_en",   {255'b0, mem_enable_o}, 256'd1);
    chk("pre_rst_addr", {224'b0, mem_addr_o},   256'h900);
    rst_i     = 1'b1;
    cpu_req_i = 1'b0;
    #1;
    chk("async_rst_en",    {255'b0, mem_enable_o}, 256'd0);
    chk("async_rst_addr",  {224'b0, mem_addr_o},   256'd0);
    chk("async_rst_stall", {255'b0, cpu_stall_o},  256'd0);
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("late_ack_en",    {255'b0, mem_enable_o}, 256'd0);
    chk("late_ack_stall", {255'b0, cpu_stall_o},  256'd0);
    chk("late_ack_rdcnt", rd_cnt - rd0, 256'd0);
    ack_late = 1'b0;

    access(1'b0, 32'h904, 32'h0, st, rd);
    chk("post_rst_stall", st, 256'd11);
    chk("post_rst_data",  {224'b0, rd}, 256'h99990001);

    access(1'b0, 32'h104, 32'h0, st, rd);
    chk("refetch_stall", st, 256'd11);
    chk("refetch_data",  {224'b0, rd}, 256'h12345678);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dcache_controller.md
# dcache_controller

Direct-mapped, write-back, write-allocate L1 data cache placed between the CPU MEM stage and off-chip data memory. It replaces the direct single-cycle data memory connection. Hits are served combinationally with no stall. Misses raise a stall to the pipeline while a finite-state machine writes back any dirty victim line and refills the new line over a 256-bit request/acknowledge memory port.

## Interface
Parameters:
- INDEX_BITS, 4, number of index bits; the cache has 2^INDEX_BITS lines. Tag width = 27 - INDEX_BITS.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- cpu_req_i  in  1  MEM stage issues an access (MemRead or MemWrite).
- cpu_we_i  in  1  1 = store, 0 = load; valid only with cpu_req_i.
- cpu_addr_i  in  32  byte address. Fields: [4:2] word, [4+INDEX_BITS:5] index, [31:5+INDEX_BITS] tag. Bits [1:0] are ignored.
- cpu_data_i  in  32  store data.
- cpu_data_o  out  32  load data; valid in any cycle where cpu_req_i=1 and cpu_stall_o=0.
- cpu_stall_o  out  1  freezes the entire pipeline.
- mem_enable_o  out  1  memory transaction request.
- mem_write_o  out  1  1 = line write-back, 0 = line read.
- mem_addr_o  out  32  line address; bits [4:0] = 0.
- mem_data_o  out  256  victim line data.
- mem_data_i  in  256  refill line data; valid when mem_ack_i=1.
- mem_ack_i  in  1  one-cycle pulse that completes a transaction.

## Operation
- Per-line storage: valid, dirty, tag, 256-bit data. Only valid and dirty are reset; tag and data arrays are not.
- Hit: cpu_req_i & valid[idx] & tag[idx]==tag(cpu_addr_i), evaluated combinationally.
- Read hit: cpu_data_o = data[idx][word*32 +: 32], same cycle.
- Write hit: at the clock edge, the addressed word takes cpu_data_i and dirty[idx] is set to 1.
- FSM states:
  - IDLE: on cpu_req_i & !hit, latch the address and go to WRITEBACK if valid[idx] & dirty[idx], otherwise go to ALLOCATE. A hit or no request stays in IDLE.
  - WRITEBACK: mem_enable_o=1, mem_write_o=1, mem_addr_o={stored tag, idx, 5'b0}, mem_data_o=data[idx]. On mem_ack_i, go to ALLOCATE.
  - ALLOCATE: mem_enable_o=1, mem_write_o=0, mem_addr_o={latched tag, idx, 5'b0}. On mem_ack_i, write mem_data_i into the line, set tag to the latched tag, valid=1, dirty=0, and go to IDLE.
- After a refill, IDLE re-evaluates the request and it now hits. A store miss completes as a write hit in that cycle and sets dirty.
- The CPU holds cpu_req_i, cpu_we_i, cpu_addr_i and cpu_data_i stable while cpu_stall_o=1. The FSM uses the latched address for all memory-side addressing.
- Outputs are zero outside WRITEBACK/ALLOCATE: mem_enable_o, mem_write_o, mem_addr_o, mem_data_o.
- mem_ack_i is ignored in IDLE.

## Timing
- Reset values: state IDLE; all valid=0, dirty=0; cpu_stall_o=0 (no request); mem_enable_o=0; mem_write_o=0; mem_addr_o=0; mem_data_o=0; cpu_data_o don't-care.
- cpu_stall_o = (state != IDLE) | (cpu_req_i & !hit). It is combinational and high in the miss-detect cycle.
- Hit latency: 0 stall cycles.
- Memory acknowledges on the k-th cycle of mem_enable_o:
  - Clean miss: stall for 1 + k cycles.
  - Dirty miss: stall for 1 + k + k cycles.
- mem_enable_o drops in the cycle after the ack edge. Back-to-back WRITEBACK→ALLOCATE keeps mem_enable_o high continuously, while mem_write_o and mem_addr_o switch.
- Reset asserted mid-transaction forces all outputs to their reset values immediately, with no clock needed. The in-flight line stays invalid, and a late mem_ack_i after reset is ignored.
- Simultaneous write hit and reset: reset wins.

## Test plan
- Reset, then cpu_req_i=0 -> cpu_stall_o=0, mem_enable_o=0. Load from 0x104 -> miss and stall.
- Cold load miss 0x0000_0104, memory k=10, line word1=0xDEADBEEF -> mem_addr_o=0x100, mem_write_o=0, stall for 11 cycles, then cpu_data_o=0xDEADBEEF with stall=0.
- Load of 0x0000_0108 immediately after -> hit, zero stall, word2 of the refilled line.
- Store 0x12345678 to 0x104 (hit), then load 0x0000_0304 (same index 8, different tag) -> WRITEBACK with mem_addr_o=0x100, mem_data_o word1=0x12345678; then ALLOCATE at 0x300; stall for 21 cycles.
- Store miss to 0x0000_0500 (clean) -> refill from 0x500, then the word is written; a following load of 0x500 returns the store data and the line is dirty (eviction via 0x700 writes back 0x500).
- rst_i pulsed on cycle 4 of ALLOCATE -> mem_enable_o=0 at once; ack on cycle 10 is ignored; a later load of the same address misses again.
